// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto byte lanes, extracts and
// extends load data, and flags misaligned or illegal-size accesses without touching memory.
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [31:0]       req_len,
    input  logic              req_unsign,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t            state, state_nxt;
    size_t             size_q, req_size;
    logic              wr_q, unsign_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              handshake, req_legal;
    logic [1:0]        off;
    logic [4:0]        shamt;
    logic [3:0]        strobe;
    logic [DATA_W-1:0] shifted, load_ext;

    assign handshake = req_valid && (state == IDLE);

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        req_size  = SZ_WORD;
        req_legal = 1'b0;
        case (req_len)
            32'd1: begin req_size = SZ_BYTE; req_legal = 1'b1;                     end
            32'd2: begin req_size = SZ_HALF; req_legal = ~req_addr[0];             end
            32'd4: begin req_size = SZ_WORD; req_legal = (req_addr[1:0] == 2'b00); end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid)     state_nxt = req_legal ? REQ : RESP;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_rsp_valid) state_nxt = RESP;
            RESP:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q     <= 1'b0;
            unsign_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (handshake) begin
                wr_q     <= req_wr;
                unsign_q <= req_unsign;
                err_q    <= ~req_legal;
                size_q   <= req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == WAIT && mem_rsp_valid) rdata_q <= mem_rdata;
        end
    end

    assign off     = addr_q[1:0];
    assign shamt   = {off, 3'b000};
    assign shifted = rdata_q >> shamt;

    always_comb begin
        strobe   = 4'b1111;
        load_ext = shifted;
        case (size_q)
            SZ_BYTE: begin
                strobe   = 4'b0001 << off;
                load_ext = {{(DATA_W-8){~unsign_q & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                strobe   = 4'b0011 << off;
                load_ext = {{(DATA_W-16){~unsign_q & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    // Memory-side fields are forced to zero outside REQ so idle cycles show a quiet bus.
    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == RESP);
    assign resp_err      = (state == RESP) && err_q;
    assign resp_rdata    = (state == RESP && !wr_q && !err_q) ? load_ext : '0;
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_we        = mem_req_valid & wr_q;
    assign mem_wstrb     = (mem_req_valid && wr_q) ? strobe : 4'b0000;
    assign mem_wdata     = mem_req_valid ? (wdata_q << shamt) : '0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, 32, address width.
REQ-002 Parameter: DATA_W, 32, data width; only 32 is supported.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  in  1  pipeline load/store request.
REQ-006 Port: req_ready  out  1  unit can accept a request.
REQ-007 Port: req_wr  in  1  1 = store, 0 = load.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data, right-justified.
REQ-010 Port: req_len  in  32  access size in bytes: 1, 2 or 4.
REQ-011 Port: req_unsign  in  1  load zero-extends when 1, sign-extends when 0.
REQ-012 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-013 Port: resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 Port: resp_err  out  1  misaligned or illegal length; valid with resp_valid.
REQ-015 Port: mem_req_valid  out  1  memory request.
REQ-016 Port: mem_req_ready  in  1  memory accepts request.
REQ-017 Port: mem_addr  out  32  word address: req_addr with bits [1:0] = 0.
REQ-018 Port: mem_we  out  1  write enable.
REQ-019 Port: mem_wstrb  out  4  byte-lane strobes.
REQ-020 Port: mem_wdata  out  32  lane-aligned store data.
REQ-021 Port: mem_rsp_valid  in  1  memory response or write acknowledge.
REQ-022 Port: mem_rdata  in  32  full read word.

Function
REQ-023 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-024 req_ready SHALL be 1 only in IDLE; a handshake (req_valid & req_ready) SHALL register wr, addr, wdata, len and unsign.
REQ-025 A legal request SHALL go IDLE->REQ; an illegal one SHALL go IDLE->RESP with no memory access.
REQ-026 Illegal: len not in {1,2,4}; len 2 with addr[0]=1; len 4 with addr[1:0]!=0.
REQ-027 In REQ, mem_req_valid SHALL be 1 with stable mem_addr/mem_we/mem_wstrb/mem_wdata until mem_req_ready; then go to WAIT.
REQ-028 In WAIT, mem_rsp_valid SHALL capture mem_rdata and go to RESP; loads and stores both wait for it.
REQ-029 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-030 In RESP, resp_valid SHALL be 1 for exactly one cycle; the next state is IDLE.
REQ-031 Minimum latency, handshake to resp_valid, with zero-wait memory: 3 cycles (REQ, WAIT, RESP); error: 1 cycle.
REQ-032 Strobes, with off = addr[1:0]:
  - len 1: 4'b0001 << off
  - len 2: 4'b0011 << off
  - len 4: 4'b1111
REQ-033 mem_wdata SHALL be wdata << (8*off); bytes outside the strobed lanes are don't-care.
REQ-034 Load data: mem_rdata >> (8*off), truncated to len bytes, then zero- or sign-extended to 32 bits per unsign.
  - len 4 is passed through unchanged.
REQ-035 mem_we SHALL equal the registered wr; for loads, mem_wstrb SHALL be 4'b0000.
REQ-036 Memory outputs SHALL be 0 whenever mem_req_valid is 0.
REQ-037 No new request SHALL be accepted before resp_valid has pulsed; there is no outstanding-transaction overlap.

Reset
REQ-038 rst_n low SHALL immediately force state IDLE and set all outputs and registers to 0.
  - Exception: req_ready SHALL be 1 while in IDLE.
REQ-039 Reset mid-transaction SHALL drop the transaction with no resp_valid; a late mem_rsp_valid SHALL be ignored.
REQ-040 The first request SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-041 The bench SHALL cover these scenarios:
  - Load, addr 0x1003, len 1, signed, mem_rdata 0x80FFFFFF -> mem_addr 0x1000, wstrb 0, resp_rdata 0xFFFFFF80, resp_err 0, resp_valid 3 cycles after handshake.
  - Same load with unsign=1 -> resp_rdata 0x00000080.
  - Store, addr 0x2002, len 2, wdata 0x0000BEEF -> mem_wstrb 4'b1100, mem_wdata[31:16] = 0xBEEF, mem_we 1; resp after mem_rsp_valid; resp_rdata 0.
  - Load, addr 0x3001, len 4 -> no mem_req_valid, resp_valid next cycle, resp_err 1, resp_rdata 0.
  - mem_req_ready held low 5 cycles -> mem_req_valid and fields stable for 5 cycles, req_ready 0 throughout.
  - rst_n pulsed low during WAIT -> outputs 0 at once, no resp_valid, next request accepted normally.
